// File: rtl/serial_compare_ctrl.sv
// Controller that compares two NBYTES-wide unsigned operands one byte per cycle, LSB slice first,
// through an external cascadable 8-bit comparator.
module serial_compare_ctrl #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    output logic [7:0]            cmp_a,
    output logic [7:0]            cmp_b,
    output logic                  cmp_l,
    output logic                  cmp_e,
    output logic                  cmp_g,
    input  logic                  cmp_lt,
    input  logic                  cmp_eq,
    input  logic                  cmp_gt,
    output logic                  busy,
    output logic                  done,
    output logic                  res_lt,
    output logic                  res_eq,
    output logic                  res_gt,
    output logic                  res_err
);

    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [8*NBYTES-1:0]   a_q, a_d;
    logic [8*NBYTES-1:0]   b_q, b_d;
    logic [2:0]            acc_q, acc_d;
    logic                  err_q, err_d;
    logic [2:0]            res_q, res_d;
    logic                  res_err_q, res_err_d;

    logic [2:0] cmp_res;
    logic       cmp_onehot;

    assign cmp_res    = {cmp_lt, cmp_eq, cmp_gt};
    assign cmp_onehot = (cmp_res == 3'b100) || (cmp_res == 3'b010) || (cmp_res == 3'b001);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        err_d     = err_q;
        res_d     = res_q;
        res_err_d = res_err_q;
        case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    idx_d   = '0;
                    acc_d   = 3'b010;
                    err_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = cmp_res;
                err_d = err_q | ~cmp_onehot;
                if (idx_q == IW'(NBYTES - 1)) begin
                    // Publish results on the same edge so they are visible throughout DONE.
                    res_d     = cmp_res;
                    res_err_d = err_q | ~cmp_onehot;
                    state_d   = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= 3'b010;
            err_q     <= 1'b0;
            res_q     <= 3'b010;
            res_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            err_q     <= err_d;
            res_q     <= res_d;
            res_err_q <= res_err_d;
        end
    end

    always_comb begin
        cmp_a = 8'h00;
        cmp_b = 8'h00;
        {cmp_l, cmp_e, cmp_g} = 3'b010;
        if (state_q == StRun) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (idx_q == IW'(i)) begin
                    cmp_a = a_q[i*8 +: 8];
                    cmp_b = b_q[i*8 +: 8];
                end
            end
            {cmp_l, cmp_e, cmp_g} = acc_q;
        end
    end

    assign start_ready = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);
    assign {res_lt, res_eq, res_gt} = res_q;
    assign res_err     = res_err_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Randomised bench for serial_compare_ctrl with a behavioural comparator and a whole-operand
// reference model.
module tb_serial_compare_ctrl;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned W      = 8 * NBYTES;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [7:0]   cmp_a;
    logic [7:0]   cmp_b;
    logic         cmp_l, cmp_e, cmp_g;
    logic         cmp_lt, cmp_eq, cmp_gt;
    logic         busy, done;
    logic         res_lt, res_eq, res_gt, res_err;
    logic         force_bad;

    int n_checks;
    int n_fail;

    serial_compare_ctrl #(.NBYTES(NBYTES)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cmp_a       (cmp_a),
        .cmp_b       (cmp_b),
        .cmp_l       (cmp_l),
        .cmp_e       (cmp_e),
        .cmp_g       (cmp_g),
        .cmp_lt      (cmp_lt),
        .cmp_eq      (cmp_eq),
        .cmp_gt      (cmp_gt),
        .busy        (busy),
        .done        (done),
        .res_lt      (res_lt),
        .res_eq      (res_eq),
        .res_gt      (res_gt),
        .res_err     (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cascadable 8-bit comparator: the local slice decides unless equal, then the cascade wins.
    always_comb begin
        if (force_bad) begin
            {cmp_lt, cmp_eq, cmp_gt} = 3'b110;
        end else if (cmp_a < cmp_b) begin
            {cmp_lt, cmp_eq, cmp_gt} = 3'b100;
        end else if (cmp_a > cmp_b) begin
            {cmp_lt, cmp_eq, cmp_gt} = 3'b001;
        end else begin
            {cmp_lt, cmp_eq, cmp_gt} = {cmp_l, cmp_e, cmp_g};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {lt,eq,gt} of the low nlow bytes of a and b as plain integers.
    function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input int nlow);
        logic [63:0] m, x, y;
        m = (64'd1 << (8 * nlow)) - 64'd1;
        x = {32'd0, a} & m;
        y = {32'd0, b} & m;
        if (x < y) return 3'b100;
        if (x > y) return 3'b001;
        return 3'b010;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                          input bit bad);
        logic [2:0] exp;
        int         lat;
        bit         seen;
        exp = ref_cmp(a, b, NBYTES);
        @(negedge clk);
        force_bad   = bad;
        start_valid = 1'b1;
        op_a        = a;
        op_b        = b;
        check("ready_idle", start_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) start_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        lat  = 0;
        seen = 0;
        for (int k = 0; k < int'(NBYTES) + 4 && !seen; k++) begin
            @(negedge clk);
            lat++;
            if (done) begin
                seen = 1;
            end else begin
                check("busy_run", busy, 1);
                check("ready_run", start_ready, 0);
                if (k < int'(NBYTES)) begin
                    check("cmp_a", cmp_a, a[k*8 +: 8]);
                    check("cmp_b", cmp_b, b[k*8 +: 8]);
                    if (!bad) check("cascade", {cmp_l, cmp_e, cmp_g}, ref_cmp(a, b, k));
                end
                if (hold) begin
                    op_a = $urandom;
                    op_b = $urandom;
                end
            end
        end
        check("done_seen", seen, 1);
        check("latency", lat, NBYTES + 1);
        if (!bad) check("result", {res_lt, res_eq, res_gt}, exp);
        check("res_err", res_err, bad);
        check("busy_done", busy, 1);
        check("ready_done", start_ready, 0);
        start_valid = 1'b0;
        force_bad   = 1'b0;
        @(negedge clk);
        check("done_pulse", done, 0);
        check("busy_idle", busy, 0);
        check("ready_back", start_ready, 1);
        if (!bad) check("result_hold", {res_lt, res_eq, res_gt}, exp);
        check("err_hold", res_err, bad);
    endtask

    task automatic abort_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bit saw_done;
        @(negedge clk);
        start_valid = 1'b1;
        op_a        = a;
        op_b        = b;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_idx2", cmp_a, a[23:16]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", start_ready, 1);
        check("abort_res", {res_lt, res_eq, res_gt}, 3'b010);
        saw_done = 0;
        repeat (NBYTES + 3) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("abort_nodone", saw_done, 0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        start_valid = 1'b1;   // reset must win over a handshake
        op_a        = 32'hDEAD_BEEF;
        op_b        = 32'h0;
        force_bad   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", start_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_res", {res_lt, res_eq, res_gt}, 3'b010);
        check("rst_err", res_err, 0);
        check("rst_casc", {cmp_l, cmp_e, cmp_g}, 3'b010);
        check("rst_cmpa", cmp_a, 0);
        check("rst_cmpb", cmp_b, 0);
        start_valid = 1'b0;
        rst         = 1'b0;

        run_op(32'h0000_0000, 32'h0000_0000, 0, 0);
        run_op(32'h0100_0000, 32'h00FF_FFFF, 0, 0);
        run_op(32'h1234_5678, 32'h1234_5679, 0, 0);
        run_op(32'hCAFE_0001, 32'h1234_0002, 1, 0);
        abort_op(32'h1111_2222, 32'h3333_4444);
        run_op(32'h5555_5555, 32'h5555_5555, 0, 1);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0:       rb = $urandom;
                1:       rb = ra;
                default: rb = ra ^ (W'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
            endcase
            run_op(ra, rb, $urandom_range(0, 3) == 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_compare_ctrl.md
SERIAL_COMPARE_CTRL -- requirements
Module: serial_compare_ctrl

Interface
REQ-001 Parameter NBYTES, default 4, number of 8-bit slices per operand (legal range 2..8).
REQ-002 Reset is synchronous and active-high on one clock, clk.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start_valid  input  1  request to compare op_a and op_b.
REQ-006 start_ready  output  1  controller can accept a request.
REQ-007 op_a  input  8*NBYTES  unsigned operand A.
REQ-008 op_b  input  8*NBYTES  unsigned operand B.
REQ-009 cmp_a  output  8  byte of A driven to the shared 8-bit cascadable comparator.
REQ-010 cmp_b  output  8  byte of B driven to the comparator.
REQ-011 cmp_l, cmp_e, cmp_g  output  1 each  cascade inputs to the comparator: lower-order less, equal, greater.
REQ-012 cmp_lt, cmp_eq, cmp_gt  input  1 each  combinational comparator results for the current slice.
REQ-013 busy  output  1  comparison in progress.
REQ-014 done  output  1  one-cycle pulse; results valid in that cycle.
REQ-015 res_lt, res_eq, res_gt  output  1 each  final A<B, A==B, A>B.
REQ-016 res_err  output  1  comparator returned a non-one-hot result during this operation.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE; start_ready SHALL be 1 only in IDLE.
REQ-018 A handshake (start_valid & start_ready at a rising edge) SHALL capture op_a and op_b into internal registers, clear idx to 0, load acc={l,e,g}=3'b010, clear the error flag and enter RUN.
REQ-019 start_valid in RUN or DONE SHALL be ignored; captured operands SHALL NOT track op_a/op_b after acceptance.
REQ-020 In RUN, cmp_a/cmp_b SHALL drive byte idx of the captured operands (idx 0 = bits 7:0, LSB first), and {cmp_l,cmp_e,cmp_g} SHALL drive acc.
REQ-021 Each RUN edge SHALL update acc <= {cmp_lt,cmp_eq,cmp_gt}, set the error flag if that triple is not one-hot, and increment idx.
REQ-022 The RUN edge with idx=NBYTES-1 SHALL move the FSM to DONE; idx SHALL NOT wrap within an operation.
REQ-023 In DONE (exactly one cycle), done=1, {res_lt,res_eq,res_gt}=acc and res_err=error flag; the next edge SHALL return the FSM to IDLE.
REQ-024 res_* and res_err SHALL hold their last values until the next DONE; done SHALL be 0 outside DONE.
REQ-025 Latency: done SHALL assert NBYTES+1 cycles after the accepting edge; throughput SHALL be one operation per NBYTES+2 cycles.
REQ-026 busy SHALL be 1 in RUN and DONE, 0 in IDLE.
REQ-027 In IDLE, cmp_a=cmp_b=0 and {cmp_l,cmp_e,cmp_g}=3'b010.
REQ-028 The final result SHALL equal the unsigned comparison of the full operands, with the MSB slice dominant, given a correct comparator.

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, idx=0, acc=3'b010, busy=0, done=0, res_lt=0, res_eq=1, res_gt=0, res_err=0, start_ready=1 after the edge.
REQ-030 rst SHALL take priority over a simultaneous handshake or RUN update; a reset during RUN SHALL abort the operation with no done pulse.

Verification
REQ-031 Assert rst for 2 cycles -> start_ready=1, busy=0, done=0, res_eq=1, cmp_e=1, cmp_a=cmp_b=0.
REQ-032 NBYTES=4, A=0x00000000, B=0x00000000 -> done at accept+5 cycles, res_eq=1, res_err=0.
REQ-033 A=0x01000000, B=0x00FFFFFF -> res_gt=1; the MSB slice overrides lower-slice lt.
REQ-034 A=0x12345678, B=0x12345679 -> res_lt=1; cmp_l=1 observed on bytes 1..3.
REQ-035 Hold start_valid high with new operands during RUN -> ignored; the result matches the first operands; the next accept occurs only in IDLE.
REQ-036 Assert rst during RUN at idx=2 -> IDLE next cycle, no done pulse; a separate run with the comparator model forced to lt=eq=1 -> res_err=1 at done.
